// File: rtl/uart_tx_bridge_pkg.sv
// Shared constants for the UART transmit bridge: bus addresses, status word layout, TX FSM states.
// Software uses the same address and bit-position values.
package uart_tx_bridge_pkg;

  localparam logic [11:0] STATUS_ADDR = 12'h800;
  localparam logic [11:0] DATA_ADDR   = 12'h801;

  localparam int ST_READY     = 0;
  localparam int ST_IDLE      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_MSB = 15;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_BUSY  = 2'd2
  } tx_state_t;

  function automatic logic [15:0] pack_status(input logic ready, input logic idle,
                                              input logic ovf, input logic [7:0] count);
    logic [15:0] word;
    word = 16'h0000;
    word[ST_READY] = ready;
    word[ST_IDLE]  = idle;
    word[ST_OVF]   = ovf;
    word[ST_COUNT_MSB:ST_COUNT_LSB] = count;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_bridge_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty come from registered pointers only,
// so a pop in the same cycle never makes room for a push.
module sync_fifo
  import uart_tx_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock_100M,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
  assign empty     = (wptr_r == rptr_r);
  assign count     = wptr_r - rptr_r;
  assign dout      = mem_r[rptr_r[AW-1:0]];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer registers
  always_ff @(posedge clock_100M or negedge n_rst) begin
    if (!n_rst) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clock_100M) begin
    if (do_push_s) mem_r[wptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_bridge.sv
// Snoops CPU stores to DATA_ADDR into a FIFO, feeds uart_tx through a start/ready handshake,
// and continuously writes a status word to the dpram second port.
module uart_tx_bridge
  import uart_tx_bridge_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CPU_RATIO = 2
) (
  input  logic        clock_100M,
  input  logic        n_rst,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        uart_ready,
  output logic        uart_start,
  output logic [7:0]  uart_data,
  output logic [11:0] stat_addr,
  output logic [15:0] stat_wdata,
  output logic        stat_we
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (CPU_RATIO > 1) ? $clog2(CPU_RATIO) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(CPU_RATIO - 1);

  logic [HW-1:0] holdoff_r;
  logic          store_s;
  logic          hit_s;
  logic          data_evt_s;
  logic          clr_evt_s;
  logic          overflow_r;
  logic          rdy_q_r;
  tx_state_t     state_r;
  tx_state_t     state_nxt_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [AW:0]   fifo_count_s;
  logic [7:0]    fifo_dout_s;
  logic [7:0]    count8_s;
  logic          uart_start_r;
  logic [7:0]    uart_data_r;
  logic [15:0]   stat_wdata_r;
  logic          stat_we_r;
  logic [7:0]    unused_wdata_s;

  // The CPU holds cpu_we for CPU_RATIO fast cycles; the holdoff turns each store into one event.
  assign store_s    = cpu_we && (holdoff_r == {HW{1'b0}});
  assign hit_s      = store_s && ((cpu_addr == DATA_ADDR) || (cpu_addr == STATUS_ADDR));
  assign data_evt_s = store_s && (cpu_addr == DATA_ADDR);
  assign clr_evt_s  = store_s && (cpu_addr == STATUS_ADDR) && cpu_wdata[ST_OVF];
  assign count8_s   = 8'(fifo_count_s);
  assign unused_wdata_s = cpu_wdata[15:8];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clock_100M (clock_100M),
    .n_rst      (n_rst),
    .push       (data_evt_s),
    .pop        (pop_s),
    .din        (cpu_wdata[7:0]),
    .dout       (fifo_dout_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count_s)
  );

  // Holdoff counter, sticky overflow flag and ready synchronizer stage
  always_ff @(posedge clock_100M or negedge n_rst) begin
    if (!n_rst) begin
      holdoff_r  <= {HW{1'b0}};
      overflow_r <= 1'b0;
      rdy_q_r    <= 1'b1;
    end else begin
      if (hit_s)                          holdoff_r <= HOLD_LOAD;
      else if (holdoff_r != {HW{1'b0}})   holdoff_r <= holdoff_r - {{(HW-1){1'b0}}, 1'b1};
      if (data_evt_s && fifo_full_s)      overflow_r <= 1'b1;
      else if (clr_evt_s)                 overflow_r <= 1'b0;
      rdy_q_r <= uart_ready;
    end
  end

  // TX FSM state register
  always_ff @(posedge clock_100M or negedge n_rst) begin
    if (!n_rst) state_r <= TX_IDLE;
    else        state_r <= state_nxt_s;
  end

  // TX FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      TX_IDLE:  if (!fifo_empty_s) state_nxt_s = TX_START; else state_nxt_s = TX_IDLE;
      TX_START: if (!rdy_q_r)      state_nxt_s = TX_BUSY;  else state_nxt_s = TX_START;
      TX_BUSY:  if (rdy_q_r)       state_nxt_s = TX_IDLE;  else state_nxt_s = TX_BUSY;
      default:  state_nxt_s = TX_IDLE;
    endcase
  end

  // TX FSM outputs: pop decision
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      TX_IDLE: pop_s = !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Registered handshake outputs and status word
  always_ff @(posedge clock_100M or negedge n_rst) begin
    if (!n_rst) begin
      uart_start_r <= 1'b0;
      uart_data_r  <= 8'h00;
      stat_wdata_r <= 16'h0000;
      stat_we_r    <= 1'b0;
    end else begin
      uart_start_r <= (state_nxt_s == TX_START);
      if (pop_s) uart_data_r <= fifo_dout_s;
      stat_wdata_r <= pack_status(!fifo_full_s, fifo_empty_s && (state_r == TX_IDLE),
                                  overflow_r, count8_s);
      stat_we_r    <= 1'b1;
    end
  end

  assign uart_start = uart_start_r;
  assign uart_data  = uart_data_r;
  assign stat_addr  = STATUS_ADDR;
  assign stat_wdata = stat_wdata_r;
  assign stat_we    = stat_we_r;

endmodule
